attn_out_collector: RTL and testbench
=====================================

ATTN_OUT_COLLECTOR -- requirements
Module: attn_out_collector

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, beat buffer entries (power of 2, >=2).
REQ-002 Parameter EXP_BEATS, default 128, beats per result (4 rows x 32 groups).
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  1-cycle pulse arming collection of one 4x128 result.
REQ-006 in_valid  input  1  stream beat present; no backpressure to producer.
REQ-007 in_row  input  2  row index of beat.
REQ-008 in_group  input  5  group index of beat.
REQ-009 in_data  input  128  four FP32 lanes, lane0 at [31:0]; passed through unmodified.
REQ-010 mem_wr_en  output  1  write request to result SRAM.
REQ-011 mem_wr_addr  output  7  write address = {row, group}.
REQ-012 mem_wr_data  output  128  write data.
REQ-013 mem_wr_ready  input  1  SRAM accepts the write this cycle.
REQ-014 busy  output  1  high from start acceptance until done.
REQ-015 done  output  1  1-cycle pulse when all beats written.
REQ-016 err_order  output  1  sticky: beat out of expected order, or beat while idle.
REQ-017 err_overflow  output  1  sticky: beat dropped because FIFO full.
REQ-018 beat_cnt  output  8  beats received in current result (0..128).

Function
REQ-019 FSM states: S_IDLE, S_COLLECT, S_DRAIN, S_DONE.
REQ-020 S_IDLE: start=1 -> S_COLLECT next cycle; busy=1; beat_cnt, expected index, err_order, err_overflow cleared.
REQ-021 start while not S_IDLE SHALL be ignored.
REQ-022 S_COLLECT: each in_valid cycle increments beat_cnt by 1 and pushes {row,group,data} unless dropped.
REQ-023 Expected order row-major: group 0..31 for row 0, then row 1..3; expected index = beat_cnt.
REQ-024 Beat with {in_row,in_group} != expected index sets err_order; beat still stored at its own address.
REQ-025 Push with FIFO full and no pop same cycle: beat dropped, err_overflow set, beat_cnt still increments.
REQ-026 Push and pop in same cycle while full SHALL succeed without overflow.
REQ-027 beat_cnt reaching EXP_BEATS -> S_DRAIN; further in_valid in S_DRAIN/S_DONE ignored and sets err_order.
REQ-028 S_DRAIN -> S_DONE when FIFO empty; S_DONE: done=1 one cycle, busy=0, -> S_IDLE.
REQ-029 mem_wr_en = FIFO not empty; addr/data = FIFO head, held stable while mem_wr_en=1 and mem_wr_ready=0.
REQ-030 Write completes and head pops on cycle with mem_wr_en & mem_wr_ready; ready while mem_wr_en=0 has no effect.
REQ-031 Latency: beat arriving at cycle t into empty FIFO drives mem_wr_en at t+1; one write per cycle max.
REQ-032 in_valid in S_IDLE ignored (not stored, not counted), sets err_order.
REQ-033 Errors remain set through done until next accepted start.

Reset
REQ-034 rst=1 at clock edge: state S_IDLE, FIFO empty, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, busy=0, done=0, err_order=0, err_overflow=0, beat_cnt=0.
REQ-035 Reset mid-operation discards buffered beats; no done pulse emitted.

Structure
REQ-036 Package attn_out_pkg holds state_t, ROWS=4, GROUPS=32, EXP_BEATS default, ADDR_W=7, beat struct {row,group,data}.
REQ-037 One sub-module, collector_fifo: synchronous FIFO, registered storage, full/empty flags, simultaneous push/pop.

Verification
REQ-038 start, 128 in-order beats back-to-back, mem_wr_ready=1 -> 128 writes addr 0..127, data matches, done 1 cycle after last write, errors 0.
REQ-039 mem_wr_ready=0 for 10 cycles after first beat, beats back-to-back -> err_overflow=1 after 5th beat, beat_cnt still reaches 128, done asserted.
REQ-040 Beat 3 sent as row 0 group 7 -> err_order=1, write to addr 7, run completes, cleared on next start.
REQ-041 mem_wr_ready toggling 1/0 each cycle, one beat every 2 cycles -> no overflow, addr/data stable during ready=0.
REQ-042 rst pulsed after 60 beats -> all outputs reset values next cycle; new start + 128 beats completes cleanly.
REQ-043 in_valid while idle, start during busy -> err_order=1, second start ignored, beat_cnt unaffected.

Source files
------------

// File: rtl/attn_out_pkg.sv
`default_nettype none
// ============================================================================
// Package  : attn_out_pkg
// Brief    : Shared types and constants for the attention-output collector:
//            result geometry, FSM state encoding and the buffered beat record.
// Revision : 1.0 - initial release
// ============================================================================
package attn_out_pkg;

    // Result geometry: 4 rows x 32 groups of 128-bit beats
    localparam int ROWS          = 4;
    localparam int GROUPS        = 32;
    localparam int EXP_BEATS_DEF = ROWS * GROUPS;

    // Field widths
    localparam int ROW_W   = 2;
    localparam int GROUP_W = 5;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 128;
    localparam int CNT_W   = 8;

    // Collector control states
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // One buffered beat: destination coordinates plus payload
    typedef struct packed {
        logic [ROW_W-1:0]   row;
        logic [GROUP_W-1:0] group;
        logic [DATA_W-1:0]  data;
    } beat_t;

    // Result SRAM address of a beat is simply {row, group}
    function automatic logic [ADDR_W-1:0] beat_addr(input beat_t b);
        return {b.row, b.group};
    endfunction

endpackage
`default_nettype wire

// File: rtl/attn_out_collector_if.sv
`default_nettype none
// ============================================================================
// Interface : attn_out_collector_if
// Brief     : Incoming beat stream plus result-SRAM write port of the
//             collector. slave = collector side, master = environment side.
// Revision  : 1.0 - initial release
// ============================================================================
interface attn_out_collector_if;
    import attn_out_pkg::*;

    // Beat stream (no backpressure)
    logic                in_valid;
    logic [ROW_W-1:0]    in_row;
    logic [GROUP_W-1:0]  in_group;
    logic [DATA_W-1:0]   in_data;

    // Result SRAM write port
    logic                mem_wr_en;
    logic [ADDR_W-1:0]   mem_wr_addr;
    logic [DATA_W-1:0]   mem_wr_data;
    logic                mem_wr_ready;

    modport slave (
        input  in_valid, in_row, in_group, in_data, mem_wr_ready,
        output mem_wr_en, mem_wr_addr, mem_wr_data
    );

    modport master (
        output in_valid, in_row, in_group, in_data, mem_wr_ready,
        input  mem_wr_en, mem_wr_addr, mem_wr_data
    );

endinterface
`default_nettype wire

// File: rtl/attn_out_collector_fifo.sv
`default_nettype none
// ============================================================================
// Module   : collector_fifo
// Brief    : Synchronous beat FIFO with registered storage, full/empty flags
//            and occupancy count. A push while full is accepted only when a
//            pop happens in the same cycle; pops while empty are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module collector_fifo
    import attn_out_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_push,
    input  wire beat_t                    i_push_beat,
    input  wire logic                     i_pop,
    output beat_t                         o_head,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(DEPTH):0]        o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    beat_t               r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_push;

    assign w_full  = (r_count == c_CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = i_pop & ~w_empty;
    // Full FIFO still takes a beat when the head leaves in the same cycle
    assign w_push  = i_push & (~w_full | w_pop);

    // Storage write; contents need no reset since head is qualified by empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_beat;
        end
    end

    // Pointer and occupancy bookkeeping (pointers wrap naturally, DEPTH is 2^n)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/attn_out_collector.sv
`default_nettype none
// ============================================================================
// Module   : attn_out_collector
// Brief    : Collects one 4x32 result of 128-bit beats from an unthrottled
//            stream, buffers them, and writes each to result SRAM at
//            {row, group}. Flags out-of-order/idle beats and FIFO overflow.
// Revision : 1.0 - initial release
// ============================================================================
module attn_out_collector
    import attn_out_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int EXP_BEATS  = EXP_BEATS_DEF
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               start,
    attn_out_collector_if.slave     bus,
    output logic                    busy,
    output logic                    done,
    output logic                    err_order,
    output logic                    err_overflow,
    output logic [CNT_W-1:0]        beat_cnt
);

    localparam int               c_FCNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(EXP_BEATS - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_beat_cnt;
    logic                   r_err_order;
    logic                   r_err_overflow;

    beat_t                  w_push_beat;
    beat_t                  w_head;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [c_FCNT_W-1:0]    w_fifo_count;
    logic                   w_pop;
    logic                   w_start_acc;
    logic                   w_collect_beat;
    logic                   w_last_beat;
    logic                   w_stray_beat;
    logic                   w_out_of_order;
    logic                   w_drop;
    logic                   w_drain_fin;
    logic [ADDR_W-1:0]      w_beat_idx;

    assign w_beat_idx     = {bus.in_row, bus.in_group};
    assign w_push_beat    = {bus.in_row, bus.in_group, bus.in_data};
    assign w_pop          = ~w_fifo_empty & bus.mem_wr_ready;
    assign w_start_acc    = (r_state == S_IDLE) & start;
    assign w_collect_beat = (r_state == S_COLLECT) & bus.in_valid;
    assign w_last_beat    = w_collect_beat & (r_beat_cnt == c_LAST_IDX);
    assign w_stray_beat   = (r_state != S_COLLECT) & bus.in_valid;
    assign w_out_of_order = w_collect_beat & (w_beat_idx != r_beat_cnt[ADDR_W-1:0]);
    assign w_drop         = w_collect_beat & w_fifo_full & ~w_pop;
    // Drain finishes on the cycle the last buffered write is accepted, so
    // done follows the final SRAM write by exactly one cycle
    assign w_drain_fin    = w_fifo_empty |
                            ((w_fifo_count == c_FCNT_W'(1)) & w_pop);

    collector_fifo #(
        .DEPTH       (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_collect_beat),
        .i_push_beat (w_push_beat),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and state-derived status outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                busy = 1'b1;
                if (w_last_beat) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (w_drain_fin) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Beat counter and sticky error flags; an accepted start clears them
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt     <= '0;
            r_err_order    <= 1'b0;
            r_err_overflow <= 1'b0;
        end else if (w_start_acc) begin
            r_beat_cnt     <= '0;
            r_err_order    <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            if (w_collect_beat) begin
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
            if (w_out_of_order | w_stray_beat) begin
                r_err_order <= 1'b1;
            end
            if (w_drop) begin
                r_err_overflow <= 1'b1;
            end
        end
    end

    assign beat_cnt         = r_beat_cnt;
    assign err_order        = r_err_order;
    assign err_overflow     = r_err_overflow;

    // SRAM port presents the FIFO head; address/data read as zero when idle
    assign bus.mem_wr_en    = ~w_fifo_empty;
    assign bus.mem_wr_addr  = w_fifo_empty ? '0 : beat_addr(w_head);
    assign bus.mem_wr_data  = w_fifo_empty ? '0 : w_head.data;

endmodule
`default_nettype wire

// File: tb/tb_attn_out_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_attn_out_collector
// Brief    : Scoreboard bench for attn_out_collector with a queue-based
//            reference model of result collection and SRAM write-out.
// Revision : 1.0 - initial release
// ============================================================================
module tb_attn_out_collector;
    import attn_out_pkg::*;

    localparam int DEPTH  = 4;
    localparam int NBEATS = 128;

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             start = 1'b0;
    logic             busy;
    logic             done;
    logic             err_order;
    logic             err_overflow;
    logic [CNT_W-1:0] beat_cnt;

    attn_out_collector_if bus();

    attn_out_collector #(
        .FIFO_DEPTH   (DEPTH),
        .EXP_BEATS    (NBEATS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .err_order    (err_order),
        .err_overflow (err_overflow),
        .beat_cnt     (beat_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- checking bookkeeping ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phases: 0 idle, 1 collecting, 2 draining, 3 done pulse
    typedef struct {
        logic [6:0]   addr;
        logic [127:0] data;
    } wr_t;

    wr_t sb_q[$];
    int  m_phase = 0;
    int  m_cnt   = 0;
    int  m_occ   = 0;
    bit  m_eo    = 0;
    bit  m_eov   = 0;
    bit  m_live  = 0;
    bit  m_just_reset = 0;
    int  mo_pop, mo_push, mo_phase, mo_idx;
    wr_t mo_w;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_phase = 0; m_cnt = 0; m_occ = 0; m_eo = 0; m_eov = 0;
                sb_q.delete();
                m_live = 1; m_just_reset = 1;
            end else begin
                m_just_reset = 0;
                mo_pop   = (bus.mem_wr_ready && m_occ > 0) ? 1 : 0;
                mo_push  = 0;
                mo_phase = m_phase;
                mo_idx   = int'(bus.in_row) * GROUPS + int'(bus.in_group);
                case (mo_phase)
                    0: begin
                        if (start) begin
                            m_phase = 1; m_cnt = 0; m_eo = 0; m_eov = 0;
                        end else if (bus.in_valid) begin
                            m_eo = 1;
                        end
                    end
                    1: begin
                        if (bus.in_valid) begin
                            if (mo_idx != m_cnt) m_eo = 1;
                            if (m_occ - mo_pop >= DEPTH) begin
                                m_eov = 1;
                            end else begin
                                mo_push = 1;
                                mo_w.addr = 7'(mo_idx);
                                mo_w.data = bus.in_data;
                                sb_q.push_back(mo_w);
                            end
                            m_cnt++;
                            if (m_cnt == NBEATS) m_phase = 2;
                        end
                    end
                    2: begin
                        if (bus.in_valid) m_eo = 1;
                        if (m_occ - mo_pop == 0) m_phase = 3;
                    end
                    default: begin
                        if (bus.in_valid) m_eo = 1;
                        m_phase = 0;
                    end
                endcase
                m_occ = m_occ - mo_pop + mo_push;
            end
        end
    end

    // ---------------- monitor ----------------
    int  ncyc = 0;
    int  last_wr_cyc = -100;
    int  n_wr = 0;

    initial begin
        forever begin
            @(negedge clk);
            ncyc++;
            if (m_live) begin
                check("busy", 128'(busy), 128'(m_phase == 1 || m_phase == 2));
                check("done", 128'(done), 128'(m_phase == 3));
                check("beat_cnt", 128'(beat_cnt), 128'(m_cnt));
                check("err_order", 128'(err_order), 128'(m_eo));
                check("err_overflow", 128'(err_overflow), 128'(m_eov));
                check("wr_en", 128'(bus.mem_wr_en), 128'(m_occ > 0));
                if (m_just_reset) begin
                    check("rst_addr", 128'(bus.mem_wr_addr), 128'(0));
                    check("rst_data", bus.mem_wr_data, 128'(0));
                end
                if (m_occ > 0 && sb_q.size() > 0) begin
                    check("wr_addr", 128'(bus.mem_wr_addr), 128'(sb_q[0].addr));
                    check("wr_data", bus.mem_wr_data, sb_q[0].data);
                    if (bus.mem_wr_ready) begin
                        void'(sb_q.pop_front());
                        n_wr++;
                        last_wr_cyc = ncyc;
                    end
                end
                if (done) begin
                    check("done_latency", 128'(ncyc - last_wr_cyc), 128'(1));
                end
            end
        end
    end

    // ---------------- SRAM ready generator ----------------
    // 0: always ready, 1: random, 2: toggle, 3: stall count then ready
    int rmode = 0;
    int stall = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: bus.mem_wr_ready = 1'b1;
                1: bus.mem_wr_ready = 1'($urandom_range(0, 1));
                2: bus.mem_wr_ready = ~bus.mem_wr_ready;
                default: begin
                    if (stall > 0) begin
                        bus.mem_wr_ready = 1'b0;
                        stall--;
                    end else begin
                        bus.mem_wr_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string nm);
        bit seen = 0;
        for (int k = 0; k < 3000; k++) begin
            if (done) begin
                seen = 1;
                break;
            end
            cyc();
        end
        if (!seen) begin
            n_chk++;
            n_err++;
            $display("FAIL %s_timeout: done not seen within 3000 cycles", nm);
        end else begin
            check({nm, "_cnt_at_done"}, 128'(beat_cnt), 128'(NBEATS));
            cyc();
        end
    endtask

    // One result: start pulse, 128 beats (optionally one out of place),
    // optional reset abort, optional start mid-run and stray beat after the end
    task automatic run(input string nm, input int gap, input int bad_idx,
                       input int bad_addr, input int abort_at,
                       input bit extra_start, input bit extra_after);
        logic [6:0] a;
        int         n;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < NBEATS; i++) begin
            if (i == abort_at) begin
                rst = 1'b1;
                cyc();
                rst = 1'b0;
                check({nm, "_rst_busy"}, 128'(busy), 128'(0));
                check({nm, "_rst_en"}, 128'(bus.mem_wr_en), 128'(0));
                check({nm, "_rst_cnt"}, 128'(beat_cnt), 128'(0));
                check({nm, "_rst_addr"}, 128'(bus.mem_wr_addr), 128'(0));
                return;
            end
            a = (i == bad_idx) ? 7'(bad_addr) : 7'(i);
            bus.in_valid = 1'b1;
            bus.in_row   = a[6:5];
            bus.in_group = a[4:0];
            bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
            if (extra_start && i == 10) start = 1'b1;
            cyc();
            bus.in_valid = 1'b0;
            start        = 1'b0;
            n = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            if (i < NBEATS - 1 || !extra_after) repeat (n) cyc();
        end
        if (extra_after) begin
            bus.in_valid = 1'b1;
            bus.in_row   = 2'd0;
            bus.in_group = 5'd0;
            cyc();
            bus.in_valid = 1'b0;
        end
        wait_done(nm);
    endtask

    initial begin
        int w0;
        bus.in_valid     = 1'b0;
        bus.in_row       = '0;
        bus.in_group     = '0;
        bus.in_data      = '0;
        bus.mem_wr_ready = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        repeat (2) cyc();

        // In-order back-to-back beats, SRAM always ready
        rmode = 0;
        w0 = n_wr;
        run("inorder", 0, -1, 0, -1, 0, 0);
        check("inorder_writes", 128'(n_wr - w0), 128'(NBEATS));
        check("inorder_eo", 128'(err_order), 128'(0));
        check("inorder_eov", 128'(err_overflow), 128'(0));

        // SRAM stalled around the first beats: overflow, run still completes
        stall = 12;
        rmode = 3;
        run("stall", 0, -1, 0, -1, 0, 0);
        check("stall_eov", 128'(err_overflow), 128'(1));
        rmode = 0;
        cyc();

        // Beat 3 carries row 0 group 7
        w0 = n_wr;
        run("order", 0, 3, 7, -1, 0, 0);
        check("order_writes", 128'(n_wr - w0), 128'(NBEATS));
        check("order_eo", 128'(err_order), 128'(1));
        check("order_eov", 128'(err_overflow), 128'(0));

        // Ready toggles every cycle, one beat every other cycle
        rmode = 2;
        w0 = n_wr;
        run("toggle", 1, -1, 0, -1, 0, 0);
        check("toggle_writes", 128'(n_wr - w0), 128'(NBEATS));
        check("toggle_eo", 128'(err_order), 128'(0));
        check("toggle_eov", 128'(err_overflow), 128'(0));
        rmode = 0;

        // Reset after 60 beats, then a clean run
        run("abort", 0, -1, 0, 60, 0, 0);
        cyc();
        run("after_rst", 0, -1, 0, -1, 0, 0);
        check("after_rst_eo", 128'(err_order), 128'(0));

        // Stray beat while idle, start while busy, stray beat after the end
        bus.in_valid = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        check("idle_beat_eo", 128'(err_order), 128'(1));
        check("idle_beat_cnt", 128'(beat_cnt), 128'(NBEATS));
        cyc();
        run("busy_start", 0, -1, 0, -1, 1, 1);
        check("busy_start_eo", 128'(err_order), 128'(1));

        // Randomised runs: random gaps, random ready, occasional misplaced beat
        rmode = 1;
        for (int r = 0; r < 3; r++) begin
            run("random", -1, int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
                -1, 0, 0);
        end
        rmode = 0;
        repeat (4) cyc();
        check("final_sb_empty", 128'(sb_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
